// File: rtl/ptw_resp_tlb_arb_if.sv
// Bus bundle between the client TLB front ends, the shared translation cache and the PTW.
// The slave modport is the cache; the master modport drives clients and the walker.
interface ptw_resp_tlb_arb_if #(
  parameter int unsigned NCLIENT = 2,
  parameter int unsigned VPN_W   = 20,
  parameter int unsigned PPN_W   = 32
);
  logic [NCLIENT-1:0]       req_valid;
  logic [NCLIENT-1:0]       req_ready;
  logic [NCLIENT*VPN_W-1:0] req_vpn;
  logic [NCLIENT-1:0]       resp_valid;
  logic                     resp_error;
  logic [PPN_W-1:0]         resp_ppn;
  logic                     ptw_req_valid;
  logic                     ptw_req_ready;
  logic [VPN_W-1:0]         ptw_req_vpn;
  logic                     ptw_resp_valid;
  logic                     ptw_resp_error;
  logic [PPN_W-1:0]         ptw_resp_ppn;
  logic                     flush;

  modport slave (
    input  req_valid, req_vpn, ptw_req_ready, ptw_resp_valid, ptw_resp_error, ptw_resp_ppn, flush,
    output req_ready, resp_valid, resp_error, resp_ppn, ptw_req_valid, ptw_req_vpn
  );

  modport master (
    output req_valid, req_vpn, ptw_req_ready, ptw_resp_valid, ptw_resp_error, ptw_resp_ppn, flush,
    input  req_ready, resp_valid, resp_error, resp_ppn, ptw_req_valid, ptw_req_vpn
  );
endinterface

// File: rtl/ptw_resp_tlb_arb.sv
// Shared fully-associative translation cache: round-robin client arbitration, hit service,
// and miss resolution through a single page-table-walker port with round-robin victim fill.
module ptw_resp_tlb_arb #(
  parameter int unsigned NCLIENT  = 2,
  parameter int unsigned NENTRIES = 4,
  parameter int unsigned VPN_W    = 20,
  parameter int unsigned PPN_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  ptw_resp_tlb_arb_if.slave   bus
);

  localparam int unsigned CW = (NCLIENT  > 1) ? $clog2(NCLIENT)  : 1;
  localparam int unsigned EW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_PTW_REQ, S_PTW_WAIT, S_RESP
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        rr_ptr_q;
  logic [CW-1:0]        client_q;
  logic [VPN_W-1:0]     vpn_q;
  logic [EW-1:0]        victim_q;
  logic [NENTRIES-1:0]  valid_q;
  logic                 flushed_q;
  logic [VPN_W-1:0]     tag_q [NENTRIES];
  logic [PPN_W-1:0]     ppn_q [NENTRIES];

  logic [NCLIENT-1:0]   resp_valid_q;
  logic                 resp_error_q;
  logic [PPN_W-1:0]     resp_ppn_q;
  logic                 ptw_req_valid_q;
  logic [VPN_W-1:0]     ptw_req_vpn_q;

  logic [VPN_W-1:0]     cli_vpn [NCLIENT];
  logic [NCLIENT-1:0]   grant_c;
  logic [CW-1:0]        grant_idx_c;
  logic                 found_c;
  int                   idx_c;
  logic                 hit_c;
  logic [EW-1:0]        hit_idx_c;
  logic                 fill_c;

  for (genvar i = 0; i < NCLIENT; i++) begin : g_cli_vpn
    assign cli_vpn[i] = bus.req_vpn[i*VPN_W +: VPN_W];
  end

  // First requesting client at or after rr_ptr, scanning cyclically; only offered in IDLE.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found_c     = 1'b0;
    idx_c       = 0;
    if (state_q == S_IDLE) begin
      for (int k = 0; k < int'(NCLIENT); k++) begin
        idx_c = (int'(rr_ptr_q) + k) % int'(NCLIENT);
        if (!found_c && bus.req_valid[CW'(idx_c)]) begin
          found_c     = 1'b1;
          grant_idx_c = CW'(idx_c);
          grant_c     = NCLIENT'(1) << CW'(idx_c);
        end
      end
    end
  end

  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int e = 0; e < int'(NENTRIES); e++) begin
      if (valid_q[EW'(e)] && (tag_q[EW'(e)] == vpn_q)) begin
        hit_c     = 1'b1;
        hit_idx_c = EW'(e);
      end
    end
  end

  // A flush anywhere in the walk, or on the fill edge itself, cancels the fill.
  assign fill_c = (state_q == S_PTW_WAIT) && bus.ptw_resp_valid && !bus.ptw_resp_error &&
                  !flushed_q && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      client_q        <= '0;
      vpn_q           <= '0;
      victim_q        <= '0;
      valid_q         <= '0;
      flushed_q       <= 1'b0;
      resp_valid_q    <= '0;
      resp_error_q    <= 1'b0;
      resp_ppn_q      <= '0;
      ptw_req_valid_q <= 1'b0;
      ptw_req_vpn_q   <= '0;
    end else begin
      resp_valid_q <= '0;
      resp_error_q <= 1'b0;
      resp_ppn_q   <= '0;
      if (bus.flush) valid_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (found_c) begin
            client_q <= grant_idx_c;
            vpn_q    <= cli_vpn[grant_idx_c];
            state_q  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          flushed_q <= 1'b0;
          if (hit_c) begin
            resp_valid_q <= NCLIENT'(1) << client_q;
            resp_ppn_q   <= ppn_q[hit_idx_c];
            state_q      <= S_RESP;
          end else begin
            ptw_req_valid_q <= 1'b1;
            ptw_req_vpn_q   <= vpn_q;
            state_q         <= S_PTW_REQ;
          end
        end
        S_PTW_REQ: begin
          if (bus.flush) flushed_q <= 1'b1;
          if (bus.ptw_req_ready) begin
            ptw_req_valid_q <= 1'b0;
            ptw_req_vpn_q   <= '0;
            state_q         <= S_PTW_WAIT;
          end
        end
        S_PTW_WAIT: begin
          if (bus.flush) flushed_q <= 1'b1;
          if (bus.ptw_resp_valid) begin
            resp_valid_q <= NCLIENT'(1) << client_q;
            resp_error_q <= bus.ptw_resp_error;
            resp_ppn_q   <= bus.ptw_resp_error ? '0 : bus.ptw_resp_ppn;
            if (fill_c) begin
              valid_q[victim_q] <= 1'b1;
              victim_q <= (victim_q == EW'(NENTRIES-1)) ? '0 : victim_q + EW'(1);
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          rr_ptr_q <= (client_q == CW'(NCLIENT-1)) ? '0 : client_q + CW'(1);
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_q[victim_q] <= vpn_q;
      ppn_q[victim_q] <= bus.ptw_resp_ppn;
    end
  end

  assign bus.req_ready     = grant_c;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_error    = resp_error_q;
  assign bus.resp_ppn      = resp_ppn_q;
  assign bus.ptw_req_valid = ptw_req_valid_q;
  assign bus.ptw_req_vpn   = ptw_req_vpn_q;

endmodule
